tapped_delay_line: RTL and testbench
====================================

# tapped_delay_line

Multi-lane, parametrised delay line with valid tracking, a runtime-selectable output tap, synchronous clear and fill accounting. It is the general-purpose successor of the fixed-tap single-lane shift register. Typical use is aligning search-window pixel rows and reference-block data ahead of the PE array. The selectable tap lets one instance serve several search offsets without re-synthesis.

## Interface

Parameters:
- DWIDTH, 8, bits per lane.
- LANES, 4, number of parallel lanes; all lanes share control.
- DEPTH, 16, number of register stages; legal range 2..256.
- TAPW, $clog2(DEPTH), derived localparam and not overridable; width of tap_sel.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance all stages by one.
- clr  in  1  synchronous clear of all stages, valids and fill.
- d  in  LANES*DWIDTH  input word; lane i occupies bits [i*DWIDTH +: DWIDTH].
- d_vld  in  1  valid tag for d, captured with d.
- tap_sel  in  TAPW  runtime tap select.
- q  out  LANES*DWIDTH  last stage (stage DEPTH-1).
- q_vld  out  1  valid tag of stage DEPTH-1.
- q_tap  out  LANES*DWIDTH  stage selected by tap_sel.
- q_tap_vld  out  1  valid tag of the tapped stage.
- fill  out  TAPW+1  count of stages holding a valid tag, 0..DEPTH.
- full  out  1  fill == DEPTH.

## Operation

- State:
  - DEPTH data stages of LANES*DWIDTH bits, named stage[0..DEPTH-1].
  - A parallel DEPTH-bit valid vector vld[0..DEPTH-1].
  - The fill counter.
- Reset (rst_n low, asynchronous): all stages, vld, and fill go to 0. Consequently q, q_tap, q_vld, q_tap_vld and full are 0. This takes effect immediately, including mid-stream; no partial shift may complete on the edge where reset is released.
- Priority on each edge: clr > en > hold.
- clr = 1:
  - All stages, vld and fill go to 0.
  - d is dropped, even if en = 1.
- en = 1, clr = 0:
  - stage[0] <= d; vld[0] <= d_vld.
  - stage[k] <= stage[k-1] and vld[k] <= vld[k-1] for k = 1..DEPTH-1.
  - fill <= fill + d_vld - vld[DEPTH-1].
- en = 0, clr = 0: all state holds. d and d_vld are ignored.
- Invalid entries still carry data; data is shifted regardless of d_vld. Only the valid bits and fill distinguish real data from bubbles.
- fill never exceeds DEPTH and never goes below 0; this follows from the update rule and must hold as an assertion.
- Tap mux:
  - q_tap = stage[tap_sel]; q_tap_vld = vld[tap_sel].
  - If DEPTH is not a power of two, tap_sel values >= DEPTH clamp to DEPTH-1.
  - tap_sel may change every cycle.
- full is decoded combinationally from the registered fill value.

## Timing

- q, q_vld, fill and full are direct register outputs, with no combinational path from any input.
- q_tap and q_tap_vld are a combinational mux of registers; the only input in that path is tap_sel.
- Latency is counted in enabled edges, not clocks:
  - d sampled on enabled edge N appears on q after edge N+DEPTH-1. It is visible on q for the cycle following that edge.
  - On q_tap, the same d appears after edge N+tap_sel.
- tap_sel = 0 gives a one-enable delay.
- Disabled cycles stretch latency 1:1 and lose no data.
- fill reflects the edge just taken. On the edge where d_vld = 1 enters and vld[DEPTH-1] = 1 leaves simultaneously, fill is unchanged.
- clr and en asserted on the same edge: the next cycle shows all zeros, and the dropped d is not counted.

## Structure

- The shared package holds:
  - a clog2 helper function,
  - a lane-slice width constant,
  - default DWIDTH/LANES values for the motion-estimation datapath.
- One sub-module, dl_stage: a single LANES*DWIDTH+1-bit register with rst_n, en and clr. Instantiate it DEPTH times in a generate loop.
- The fill counter, full decode and tap mux stay in the top level.

## Test plan

- Reset release, then DEPTH=16, LANES=4, en held high, d_vld=1, d = incrementing lane values (lane i = 4k+i for word k) -> q shows word 0 on the cycle after edge 16. fill increments 1..16. full asserts on the cycle after edge 16 and stays high.
- Alternate en 1/0 with incrementing data -> q sequence identical to the continuous case, with latency 2x in clocks. fill changes only on enabled edges.
- Sweep tap_sel 0..15 with an impulse (single word 0xA5 in all lanes, d_vld=1, then d_vld=0) -> q_tap_vld is high exactly when the impulse sits at stage tap_sel. q_tap = 0xA5A5A5A5 at that point.
- Stream with d_vld pattern 1,0,1,1,0, repeating -> fill matches a reference count of valid bits in flight at every cycle and never leaves 0..16.
- clr and en both high with d_vld=1 while full -> next cycle fill=0, q_vld=0, q=0. The dropped word never appears on q.
- Assert rst_n low mid-stream, asynchronously to clk -> all outputs are 0 before the next edge. After release, the stream restarts cleanly with a full DEPTH latency.

Source files
------------

// File: rtl/tapped_delay_line_pkg.sv
// Shared constants and helpers for the tapped delay line and its users.
package tapped_delay_line_pkg;

  // Defaults for the motion-estimation datapath: 8-bit pixels, 4 lanes.
  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_LANES    = 4;
  // Width of one lane slice inside a packed word.
  localparam int LANE_SLICE_W = DEF_DWIDTH;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tapped_delay_line_if.sv
// Bus bundle between a producer/consumer and the tapped delay line.
//
// Flow control: en is the only qualifier. There is no ready/backpressure;
// on a rising clk edge with en=1 (and clr=0) d/d_vld are consumed and every
// stage advances, otherwise inputs are ignored and all state holds.
// d_vld tags the word; it does not gate the shift.
interface tapped_delay_line_if
  import tapped_delay_line_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = 16
);
  localparam int TAPW = clog2(DEPTH);
  localparam int W    = LANES * DWIDTH;

  logic            en;
  logic            clr;
  logic [W-1:0]    d;
  logic            d_vld;
  logic [TAPW-1:0] tap_sel;
  logic [W-1:0]    q;
  logic            q_vld;
  logic [W-1:0]    q_tap;
  logic            q_tap_vld;
  logic [TAPW:0]   fill;
  logic            full;

  modport master (
    output en, clr, d, d_vld, tap_sel,
    input  q, q_vld, q_tap, q_tap_vld, fill, full
  );

  modport slave (
    input  en, clr, d, d_vld, tap_sel,
    output q, q_vld, q_tap, q_tap_vld, fill, full
  );
endinterface

// File: rtl/tapped_delay_line_dl_stage.sv
// One delay-line stage: a word register with clear and enable.
module dl_stage
  import tapped_delay_line_pkg::*;
#(
  parameter int W = DEF_LANES * DEF_DWIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: clear wins over enable, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (clr_i)     data_d = '0;
    else if (en_i) data_d = d_i;
  end

  // Stage register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

// File: rtl/tapped_delay_line.sv
// Multi-lane delay line with valid tags, runtime output tap and fill count.
// Each stage stores {valid, data}; the valid bit sits at the MSB.
module tapped_delay_line
  import tapped_delay_line_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  tapped_delay_line_if.slave  bus
);
  localparam int TAPW = clog2(DEPTH);
  localparam int SW   = LANES * DWIDTH + 1;
  localparam logic [TAPW:0] FILL_MAX = DEPTH[TAPW:0];
  localparam logic [TAPW:0] FILL_ONE = {{TAPW{1'b0}}, 1'b1};

  logic [DEPTH-1:0][SW-1:0] stage_q;
  logic [TAPW:0]            fill_q;
  logic [TAPW:0]            fill_d;
  logic                     vld_last;
  logic [SW-1:0]            tap_word;

  // Chain of stages; stage 0 captures the tagged input word.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [SW-1:0] stage_in;
    if (k == 0) begin : g_head
      assign stage_in = {bus.d_vld, bus.d};
    end else begin : g_body
      assign stage_in = stage_q[k-1];
    end
    dl_stage #(.W(SW)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (bus.en),
      .clr_i (bus.clr),
      .d_i   (stage_in),
      .q_o   (stage_q[k])
    );
  end

  assign vld_last = stage_q[DEPTH-1][SW-1];

  // Fill tracks valid tags in flight: +1 on entry, -1 on exit, net zero for both.
  always_comb begin
    fill_d = fill_q;
    if (bus.clr) begin
      fill_d = '0;
    end else if (bus.en) begin
      if (bus.d_vld && !vld_last)      fill_d = fill_q + FILL_ONE;
      else if (!bus.d_vld && vld_last) fill_d = fill_q - FILL_ONE;
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  // Tap mux; selects with no matching stage fall back to the last stage,
  // which clamps out-of-range selects when DEPTH is not a power of two.
  always_comb begin
    tap_word = stage_q[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.tap_sel == TAPW'(k)) tap_word = stage_q[k];
    end
  end

  assign bus.q         = stage_q[DEPTH-1][SW-2:0];
  assign bus.q_vld     = vld_last;
  assign bus.q_tap     = tap_word[SW-2:0];
  assign bus.q_tap_vld = tap_word[SW-1];
  assign bus.fill      = fill_q;
  assign bus.full      = (fill_q == FILL_MAX);

  // The fill count can never leave 0..DEPTH (underflow would wrap above DEPTH).
  a_fill_range: assert property (@(posedge clk) disable iff (!rst_n) fill_q <= FILL_MAX);

endmodule

// File: tb/tb_tapped_delay_line.sv
// Bench for tapped_delay_line: directed table, corner sequences, random stream.
module tb_tapped_delay_line;
  import tapped_delay_line_pkg::*;

  localparam int DWIDTH = 8;
  localparam int LANES  = 4;
  localparam int DEPTH  = 16;
  localparam int W      = LANES * DWIDTH;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  // {valid, data} of every accepted word since the last clear/reset,
  // newest at the back, trimmed to DEPTH entries.
  logic [W:0] exp_q[$];

  tapped_delay_line_if #(.DWIDTH(DWIDTH), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  tapped_delay_line #(.DWIDTH(DWIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_edge();
    if (bus.clr) begin
      exp_q.delete();
    end else if (bus.en) begin
      exp_q.push_back({bus.d_vld, bus.d});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
  endtask

  // Word that sits k enables deep: the one accepted k enables ago, else reset zero.
  function automatic logic [W:0] exp_at(input int t);
    int tt;
    int idx;
    tt  = (t > DEPTH - 1) ? DEPTH - 1 : t;
    idx = exp_q.size() - 1 - tt;
    if (idx >= 0) return exp_q[idx];
    return '0;
  endfunction

  function automatic int exp_fill();
    int c;
    c = 0;
    foreach (exp_q[i]) if (exp_q[i][W]) c++;
    return c;
  endfunction

  function automatic logic [W-1:0] word(input int k);
    logic [W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*LANE_SLICE_W +: LANE_SLICE_W] = 8'(4 * k + i);
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W:0] e_last;
    logic [W:0] e_tap;
    int         f;
    e_last = exp_at(DEPTH - 1);
    e_tap  = exp_at(int'(bus.tap_sel));
    f      = exp_fill();
    check({tag, ".q"},         64'(bus.q),         64'(e_last[W-1:0]));
    check({tag, ".q_vld"},     64'(bus.q_vld),     64'(e_last[W]));
    check({tag, ".q_tap"},     64'(bus.q_tap),     64'(e_tap[W-1:0]));
    check({tag, ".q_tap_vld"}, 64'(bus.q_tap_vld), 64'(e_tap[W]));
    check({tag, ".fill"},      64'(bus.fill),      64'(f));
    check({tag, ".full"},      64'(bus.full),      64'(f == DEPTH));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic en, input logic clr, input logic vld,
                       input logic [W-1:0] d, input int tap);
    bus.en      = en;
    bus.clr     = clr;
    bus.d_vld   = vld;
    bus.d       = d;
    bus.tap_sel = 4'(tap);
    step();
  endtask

  typedef struct {
    logic         en;
    logic         clr;
    logic         vld;
    logic [W-1:0] d;
    int           tap;
    int           e_fill;
    logic         e_tap_vld;
    logic [W-1:0] e_tap;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] rd;
    int           k;
    n_checks = 0;
    n_err    = 0;

    // Directed vectors with hand-derived expectations, starting from empty.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h11111111, 0, 1, 1'b1, 32'h11111111};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h22222222, 1, 1, 1'b1, 32'h11111111};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h33333333, 1, 1, 1'b1, 32'h11111111};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h44444444, 0, 2, 1'b1, 32'h44444444};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h55555555, 2, 3, 1'b0, 32'h22222222};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h66666666, 0, 0, 1'b0, 32'h00000000};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h77777777, 0, 0, 1'b0, 32'h77777777};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h88888888, 1, 1, 1'b0, 32'h77777777};

    // ---- reset ----
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.d_vld   = 1'b0;
    bus.d       = '0;
    bus.tap_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed table ----
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].vld, vecs[i].d, vecs[i].tap);
      check($sformatf("vec%0d.fill", i),    64'(bus.fill),      64'(vecs[i].e_fill));
      check($sformatf("vec%0d.tap_vld", i), 64'(bus.q_tap_vld), 64'(vecs[i].e_tap_vld));
      check($sformatf("vec%0d.tap", i),     64'(bus.q_tap),     64'(vecs[i].e_tap));
      check_all($sformatf("vec%0d", i));
    end

    // ---- continuous fill ----
    drive(1'b0, 1'b1, 1'b0, '0, 0);
    for (int i = 0; i < DEPTH + 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, word(i), 15);
      check($sformatf("cont%0d.fill", i), 64'(bus.fill), 64'((i + 1 > DEPTH) ? DEPTH : i + 1));
      check($sformatf("cont%0d.full", i), 64'(bus.full), 64'(i >= DEPTH - 1));
      if (i == DEPTH - 1) check("cont.q_word0", 64'(bus.q), 64'(word(0)));
      check_all($sformatf("cont%0d", i));
    end

    // ---- alternating enable ----
    drive(1'b0, 1'b1, 1'b0, '0, 0);
    k = 0;
    for (int c = 0; c < 2 * DEPTH + 2; c++) begin
      drive(c % 2 == 0, 1'b0, 1'b1, word(k), 3);
      if (c % 2 == 0) k++;
      if (c == 2 * DEPTH - 2) check("alt.q_word0", 64'(bus.q), 64'(word(0)));
      if (c == 2 * DEPTH - 1) check("alt.q_hold", 64'(bus.q), 64'(word(0)));
      check_all($sformatf("alt%0d", c));
    end

    // ---- impulse sweep over every tap ----
    for (int t = 0; t < DEPTH; t++) begin
      drive(1'b0, 1'b1, 1'b0, '0, t);
      drive(1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, t);
      for (int s = 0; s < DEPTH; s++) begin
        check($sformatf("imp%0d_%0d.tap_vld", t, s), 64'(bus.q_tap_vld), 64'(s == t));
        if (s == t) begin
          check($sformatf("imp%0d.tap", t), 64'(bus.q_tap), 64'h00000000A5A5A5A5);
          check_all($sformatf("imp%0d", t));
        end
        drive(1'b1, 1'b0, 1'b0, '0, t);
      end
    end

    // ---- valid pattern 1,0,1,1,0 ----
    drive(1'b0, 1'b1, 1'b0, '0, 0);
    for (int i = 0; i < 50; i++) begin
      rd = $urandom;
      drive(1'b1, 1'b0, (i % 5 == 0) || (i % 5 == 2) || (i % 5 == 3), rd, $urandom_range(0, DEPTH - 1));
      check($sformatf("pat%0d.range", i), 64'(bus.fill <= 5'(DEPTH)), 64'd1);
      check_all($sformatf("pat%0d", i));
    end

    // ---- clear while full, with en and d_vld ----
    drive(1'b0, 1'b1, 1'b0, '0, 0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b1, word(i), 0);
    check("clrfull.pre_full", 64'(bus.full), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 0);
    check("clrfull.fill",  64'(bus.fill),  64'd0);
    check("clrfull.q_vld", 64'(bus.q_vld), 64'd0);
    check("clrfull.q",     64'(bus.q),     64'd0);
    check_all("clrfull");
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 0);
      check($sformatf("clrfull%0d.no_dead", i), 64'(bus.q == 32'hDEADBEEF), 64'd0);
      check_all($sformatf("clrfull%0d", i));
    end

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, word(i + 40), 5);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check_all("areset");
    bus.en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, word(i + 60), 0);
      check($sformatf("restart%0d.q_vld", i), 64'(bus.q_vld), 64'(i >= DEPTH - 1));
      if (i == DEPTH - 1) check("restart.q_first", 64'(bus.q), 64'(word(60)));
      check_all($sformatf("restart%0d", i));
    end

    // ---- random stream ----
    for (int i = 0; i < 400; i++) begin
      rd = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
            1'($urandom_range(0, 1)), rd, $urandom_range(0, DEPTH - 1));
      check_all($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
